// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file.
// Holds the two-state controller encoding and the default sizing constants
// used by regfile_param and rf_read_port.
package regfile_pkg;

   // Controller states: CLEAR walks every entry to zero, READY serves traffic
   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_READY = 1'b1
   } rfState_t;

   // Default sizing of the register file
   localparam int RF_DATA_W   = 32;
   localparam int RF_ADDR_W   = 5;
   localparam int RF_NUM_RD   = 2;
   localparam int RF_ZERO_REG = 1;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Picks between the stored entry, the in-flight write data (write-through
// bypass) and a forced zero (busy, or protected entry 0).
// Ports:
//   busy       - clear sequence running; forces the output to zero
//   bypassEn   - a write is actually landing this cycle (already qualified)
//   writeReg   - address of that write
//   writeData  - data of that write
//   addr       - address presented on this port
//   storedData - array contents at addr
//   data       - resolved read data
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int ZERO_REG = RF_ZERO_REG
) (
   input  logic              busy,
   input  logic              bypassEn,
   input  logic [ADDR_W-1:0] writeReg,
   input  logic [DATA_W-1:0] writeData,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] storedData,
   output logic [DATA_W-1:0] data
);

   // Priority: busy blanks everything, then the zero register wins over any
   // bypass or stale contents, then a matching write is forwarded so the
   // reader sees the new value in the same cycle, else the array is used.
   always_comb begin
      data = '0;
      if (!busy) begin
         if ((ZERO_REG != 0) && (addr == '0)) begin
            data = '0;
         end else if (bypassEn && (writeReg == addr)) begin
            data = writeData;
         end else begin
            data = storedData;
         end
      end
   end

endmodule

// File: rtl/regfile_param.sv
// Parameterised multi-read, single-write register file with a self-clearing
// start-up sequence.
// After reset the controller spends exactly DEPTH cycles zeroing one entry per
// cycle (busy=1, reads return 0, writes ignored), then enters READY.
// Ports:
//   clk       - sole clock, rising edge
//   rst       - synchronous active-high reset; restarts the clear sequence
//   regWrite  - write enable
//   writeReg  - write address
//   writeData - write data
//   readAddr  - NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   readData  - NUM_RD packed read results, port k at [k*DATA_W +: DATA_W]
//   busy      - high while the clear sequence runs
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = RF_NUM_RD,
   parameter int ZERO_REG = RF_ZERO_REG
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     regWrite,
   input  logic [ADDR_W-1:0]        writeReg,
   input  logic [DATA_W-1:0]        writeData,
   input  logic [NUM_RD*ADDR_W-1:0] readAddr,
   output logic [NUM_RD*DATA_W-1:0] readData,
   output logic                     busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   rfState_t          state;
   rfState_t          nextState;
   logic [ADDR_W-1:0] clrCnt;
   logic [ADDR_W-1:0] nextCnt;
   logic              writeOk;
   logic [DATA_W-1:0] mem [DEPTH];

   // State and clear-counter register. Reset always restarts the sweep from
   // entry 0, even when it arrives halfway through a previous sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RF_CLEAR;
         clrCnt <= '0;
      end else begin
         state  <= nextState;
         clrCnt <= nextCnt;
      end
   end

   // Next-state logic. The counter wraps to zero on the same edge that clears
   // the last entry, which is exactly when we leave CLEAR, so READY always
   // finds it back at zero for the next sweep.
   always_comb begin
      nextState = state;
      nextCnt   = clrCnt;
      case (state)
         RF_CLEAR: begin
            nextCnt = clrCnt + 1'b1;
            if (clrCnt == {ADDR_W{1'b1}}) begin
               nextState = RF_READY;
            end
         end
         RF_READY: begin
            nextState = RF_READY;
         end
         default: begin
            nextState = RF_CLEAR;
         end
      endcase
   end

   // Busy comes straight from the registered state, so it is glitch-free and
   // independent of any input this cycle.
   always_comb begin
      busy = (state == RF_CLEAR);
   end

   // A write only counts when we are serving traffic and it does not target
   // the hard-wired zero entry. Readers use the same qualifier for bypass so
   // the forwarded value always matches what will be stored.
   always_comb begin
      writeOk = (state == RF_READY) && regWrite &&
                !((ZERO_REG != 0) && (writeReg == '0));
   end

   // Single write port into the storage array. No reset on the array itself
   // so it maps onto distributed RAM; zeroing is done by the clear sweep, and
   // an edge with rst high never modifies the array.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == RF_CLEAR) begin
            mem[clrCnt] <= '0;
         end else if (writeOk) begin
            mem[writeReg] <= writeData;
         end
      end
   end

   // One independent read port per requested reader.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rdPort
      rf_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_rdPort (
         .busy       (busy),
         .bypassEn   (writeOk),
         .writeReg   (writeReg),
         .writeData  (writeData),
         .addr       (readAddr[k*ADDR_W +: ADDR_W]),
         .storedData (mem[readAddr[k*ADDR_W +: ADDR_W]]),
         .data       (readData[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a default-sized instance (32x32, two
// read ports) and a small instance (8x8, four read ports).
module tb_regfile_param;

   logic        clk = 1'b0;

   logic        rstA;
   logic        regWriteA;
   logic [4:0]  writeRegA;
   logic [31:0] writeDataA;
   logic [9:0]  readAddrA;
   logic [63:0] readDataA;
   logic        busyA;

   logic        rstB;
   logic        regWriteB;
   logic [2:0]  writeRegB;
   logic [7:0]  writeDataB;
   logic [11:0] readAddrB;
   logic [31:0] readDataB;
   logic        busyB;

   int checks   = 0;
   int failures = 0;

   // Free-running 10-unit clock shared by both instances
   always #5 clk = ~clk;

   regfile_param dutA (
      .clk       (clk),
      .rst       (rstA),
      .regWrite  (regWriteA),
      .writeReg  (writeRegA),
      .writeData (writeDataA),
      .readAddr  (readAddrA),
      .readData  (readDataA),
      .busy      (busyA)
   );

   regfile_param #(
      .DATA_W   (8),
      .ADDR_W   (3),
      .NUM_RD   (4),
      .ZERO_REG (1)
   ) dutB (
      .clk       (clk),
      .rst       (rstB),
      .regWrite  (regWriteB),
      .writeReg  (writeRegB),
      .writeData (writeDataB),
      .readAddr  (readAddrB),
      .readData  (readDataB),
      .busy      (busyB)
   );

   // Compare one observed value against its expected value and log misses
   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive all inputs of the default instance and let the read path settle
   task automatic applyStimulus(input logic rst, input logic we,
                                input logic [4:0] wreg, input logic [31:0] wdata,
                                input logic [4:0] rd1, input logic [4:0] rd0);
      rstA       = rst;
      regWriteA  = we;
      writeRegA  = wreg;
      writeDataA = wdata;
      readAddrA  = {rd1, rd0};
      #1;
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count cycles until busy drops on the default instance, bounded
   task automatic countBusyA(output int n);
      n = 0;
      while (busyA !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
   endtask

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [11:0] addrVec [5];
   logic [31:0] expVec  [5];

   initial begin
      int n;
      logic [63:0] orAll;

      addrVec = '{12'o3210, 12'o7777, 12'o1357, 12'o0246, 12'o5050};
      expVec  = '{32'h33221100, 32'h77777777, 32'h11335577,
                  32'h00224466, 32'h55005500};

      rstB = 1'b1; regWriteB = 1'b0; writeRegB = '0; writeDataB = '0;
      readAddrB = '0;
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      tick();

      rstB = 1'b0;
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
      checkOutput("reset busy", {63'h0, busyA}, 64'h1);
      checkOutput("reset read", readDataA, 64'h0);
      checkOutput("small reset busy", {63'h0, busyB}, 64'h1);
      checkOutput("small reset read", {32'h0, readDataB}, 64'h0);

      countBusyA(n);
      checkOutput("clear length", 64'(n), 64'd32);
      checkOutput("small ready", {63'h0, busyB}, 64'h0);

      orAll = '0;
      for (int a = 0; a < 32; a++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
         orAll = orAll | readDataA;
      end
      checkOutput("cleared contents", orAll, 64'h0);

      applyStimulus(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7);
      checkOutput("r7 bypass", readDataA, 64'hDEADBEEF_DEADBEEF);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
      checkOutput("r7 stored", readDataA, 64'hDEADBEEF_DEADBEEF);

      applyStimulus(1'b0, 1'b1, 5'd10, 32'hA5A5A5A5, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b1, 5'd9, 32'h12345678, 5'd10, 5'd9);
      checkOutput("bypass port0", {32'h0, readDataA[31:0]}, 64'h12345678);
      checkOutput("stored port1", {32'h0, readDataA[63:32]}, 64'hA5A5A5A5);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd9);
      checkOutput("r9 r10 stored", readDataA, 64'hA5A5A5A5_12345678);

      applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      checkOutput("r0 during write", readDataA, 64'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      checkOutput("r0 after write", readDataA, 64'h0);

      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd9);
      checkOutput("rerun busy", {63'h0, busyA}, 64'h1);
      checkOutput("rerun read", readDataA, 64'h0);
      for (int i = 0; i < 15; i++) begin
         tick();
      end
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b1, 5'd4, 32'h44444444, 5'd4, 5'd4);
      checkOutput("busy blocks read", readDataA, 64'h0);
      countBusyA(n);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd4);
      checkOutput("restart length", 64'(n), 64'd32);
      checkOutput("lost write and r7 cleared", readDataA, 64'h0);

      for (int i = 0; i < 8; i++) begin
         regWriteB  = 1'b1;
         writeRegB  = 3'(i);
         writeDataB = (i == 0) ? 8'h99 : 8'(i * 17);
         tick();
      end
      regWriteB = 1'b0;
      for (int i = 0; i < 5; i++) begin
         readAddrB = addrVec[i];
         #1;
         checkOutput($sformatf("small ports vec%0d", i), {32'h0, readDataB},
                     {32'h0, expVec[i]});
      end

      regWriteB  = 1'b1;
      writeRegB  = 3'd2;
      writeDataB = 8'hAB;
      readAddrB  = 12'o2221;
      #1;
      checkOutput("small bypass all ports", {32'h0, readDataB}, 64'hABABAB11);
      tick();
      regWriteB = 1'b0;
      readAddrB = 12'o0022;
      #1;
      checkOutput("small r2 stored", {32'h0, readDataB}, 64'h0000ABAB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 32, bit width of each register entry.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and is never written.
REQ-005 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset; starts the clear sequence.
REQ-008 regWrite  input  1  write enable.
REQ-009 writeReg  input  ADDR_W  write address.
REQ-010 writeData  input  DATA_W  write data.
REQ-011 readAddr  input  NUM_RD*ADDR_W  flattened read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-012 readData  output  NUM_RD*DATA_W  flattened read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-013 busy  output  1  high while the clear sequence runs; writes are ignored and reads return 0.

Function
REQ-014 Two states SHALL exist: CLEAR and READY; no other states.
REQ-015 In CLEAR, one entry per cycle SHALL be written to 0 at index clr_cnt, and clr_cnt SHALL increment by 1.
REQ-016 CLEAR SHALL transition to READY on the edge that clears entry DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
REQ-017 busy SHALL equal 1 in CLEAR and 0 in READY, driven from registered state.
REQ-018 In READY, with regWrite=1, writeData SHALL be stored at writeReg on the rising edge, except writeReg=0 when ZERO_REG=1, which is silently dropped.
REQ-019 Reads SHALL be combinational, with zero cycles of latency from readAddr to readData.
REQ-020 Write-through bypass: when READY, regWrite=1, writeReg equals port k's address, and that address is not zero-protected, port k SHALL return writeData in the same cycle.
REQ-021 Each port SHALL resolve independently; identical addresses on several ports return identical data, including when bypassed.
REQ-022 Port k address 0 with ZERO_REG=1 SHALL return 0 regardless of bypass or storage contents.
REQ-023 While busy=1, all readData bits SHALL be 0 and regWrite SHALL have no effect.
REQ-024 clr_cnt SHALL be ADDR_W bits wide and wrap naturally; the wrap coincides with the CLEAR-to-READY transition.
REQ-025 No arithmetic is performed on data; widths are exact, with no truncation or extension.

Reset
REQ-026 rst=1 at a rising edge SHALL force state=CLEAR and clr_cnt=0; busy reads 1 from the next cycle.
REQ-027 rst asserted mid-CLEAR SHALL restart the sequence from clr_cnt=0.
REQ-028 rst asserted in READY with regWrite=1 SHALL drop that write.
REQ-029 Storage contents before the first completed CLEAR are undefined; no initial blocks or preloaded values.
REQ-030 Reset values: busy=1 and readData=0 for every port, both held until READY.

Structure
REQ-031 The state encoding (RF_CLEAR, RF_READY) and default parameter constants SHALL live in shared package regfile_pkg.
REQ-032 Per-port bypass/zero selection SHALL be one sub-module, rf_read_port, instantiated NUM_RD times by generate loop.
REQ-033 Storage SHALL be a single DEPTH x DATA_W array with one write port, inferable as distributed RAM plus read muxes.

Verification
REQ-034 Scenario: rst high for 1 cycle, then low -> busy=1 for exactly 32 cycles, then 0; every address reads 0.
REQ-035 Scenario: READY, write 0xDEADBEEF to r7; the next cycle read r7 on both ports -> both return 0xDEADBEEF.
REQ-036 Scenario: same cycle regWrite=1, writeReg=9, writeData=0x12345678, readAddr port0=9 -> port0=0x12345678 that cycle (bypass); port1=10 returns the stored value.
REQ-037 Scenario: write 0xFFFFFFFF to r0 with ZERO_REG=1 -> r0 reads 0 both during the write cycle and after.
REQ-038 Scenario: rst at clear cycle 15 -> busy stays high 32 further cycles; a write attempted during busy is lost (target reads 0 afterwards).
REQ-039 Scenario: NUM_RD=4, ADDR_W=3, DATA_W=8; write r1..r7 with values 0x11..0x77 -> all four ports read correct values for arbitrary address combinations.
